// File: rtl/uart_pkg.sv
// Shared UART constants and helpers, used by the baud generator and the TX/RX engines.
package uart_pkg;

    // Default accumulator width and oversample ratio.
    localparam int unsigned UART_ACC_W      = 24;
    localparam int unsigned UART_OVERSAMPLE = 16;

    // round(16 * 9600 * 2^24 / 50e6): 9600 baud at 16x oversampling from a 50 MHz clock.
    localparam int unsigned UART_DEFAULT_INC = 51540;

    // Registered tick outputs of the generator, kept together so they clear as one.
    typedef struct packed {
        logic os;   // oversample tick
        logic bnd;  // bit boundary
        logic mid;  // mid-bit
    } tick_t;

    // Phase increment for a given clock and baud rate, rounded to nearest.
    function automatic longint unsigned calc_inc(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input int unsigned     oversample,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = (64'(oversample) * baud) << acc_w;
        return (num + (clk_hz / 2)) / clk_hz;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between the baud generator and its user (TX/RX engines, CSR block).
interface uart_baud_gen_if
    import uart_pkg::*;
#(
    parameter int unsigned ACC_W      = UART_ACC_W,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
);
    localparam int unsigned PH_W = $clog2(OVERSAMPLE);

    logic             en;
    logic             resync;
    logic             inc_wr;
    logic [ACC_W-1:0] inc_in;
    logic             inc_busy;
    logic             os_tick;
    logic             bit_tick;
    logic             mid_tick;
    logic [PH_W-1:0]  os_phase;

    // User side: drives control, consumes ticks.
    modport master (
        output en, resync, inc_wr, inc_in,
        input  inc_busy, os_tick, bit_tick, mid_tick, os_phase
    );

    // Generator side.
    modport slave (
        input  en, resync, inc_wr, inc_in,
        output inc_busy, os_tick, bit_tick, mid_tick, os_phase
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Fractional (NCO) UART baud generator: oversample, bit-boundary and mid-bit tick pulses,
// runtime-programmable increment applied only between bits, and start-edge phase resync.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned ACC_W       = UART_ACC_W,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned DEFAULT_INC = UART_DEFAULT_INC
) (
    input  logic           clkin,
    input  logic           rst,
    uart_baud_gen_if.slave bus
);

    localparam int unsigned     PH_W    = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);
    localparam logic [ACC_W-1:0] INC_RST = ACC_W'(DEFAULT_INC);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]  os_cnt_q, os_cnt_d;
    tick_t            tick_q, tick_d;
    logic [ACC_W-1:0] inc_cur_q, inc_cur_d;
    logic [ACC_W-1:0] inc_pend_q, inc_pend_d;
    logic             pend_v_q, pend_v_d;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic             wrap;
    logic             apply;

    // Next-state decode: carry out of the phase add, bit wrap, and safe points to swap the rate.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, inc_cur_q};
        carry = bus.en && !bus.resync && sum[ACC_W];
        wrap  = carry && (os_cnt_q == PH_LAST);
        // Rate changes land only where they cannot stretch or shrink a bit in flight.
        apply = !bus.en || bus.resync || wrap;

        acc_d = acc_q;
        if (bus.resync) begin
            acc_d = '0;
        end else if (bus.en) begin
            acc_d = sum[ACC_W-1:0];
        end

        os_cnt_d = os_cnt_q;
        tick_d   = '0;
        if (bus.resync) begin
            os_cnt_d = '0;
        end else if (carry) begin
            os_cnt_d   = wrap ? '0 : os_cnt_q + 1'b1;
            tick_d.os  = 1'b1;
            tick_d.bnd = wrap;
            tick_d.mid = (os_cnt_d == PH_MID);
        end

        inc_cur_d  = inc_cur_q;
        inc_pend_d = inc_pend_q;
        pend_v_d   = pend_v_q;
        if (bus.inc_wr) begin
            if (apply) begin
                inc_cur_d = bus.inc_in;
                pend_v_d  = 1'b0;
            end else begin
                inc_pend_d = bus.inc_in;
                pend_v_d   = 1'b1;
            end
        end else if (pend_v_q && apply) begin
            inc_cur_d = inc_pend_q;
            pend_v_d  = 1'b0;
        end
    end

    // Phase accumulator.
    always_ff @(posedge clkin) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Oversample counter and registered tick pulses.
    always_ff @(posedge clkin) begin
        if (rst) begin
            os_cnt_q <= '0;
            tick_q   <= '0;
        end else begin
            os_cnt_q <= os_cnt_d;
            tick_q   <= tick_d;
        end
    end

    // Increment shadow register: holds a written rate until the next safe point.
    always_ff @(posedge clkin) begin
        if (rst) begin
            inc_cur_q  <= INC_RST;
            inc_pend_q <= '0;
            pend_v_q   <= 1'b0;
        end else begin
            inc_cur_q  <= inc_cur_d;
            inc_pend_q <= inc_pend_d;
            pend_v_q   <= pend_v_d;
        end
    end

    assign bus.os_tick  = tick_q.os;
    assign bus.bit_tick = tick_q.bnd;
    assign bus.mid_tick = tick_q.mid;
    assign bus.os_phase = os_cnt_q;
    assign bus.inc_busy = pend_v_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: a small 8-bit instance (inc 64, 4-cycle tick period) exercised with
// directed scenarios against a tick scoreboard, and a default-parameter instance free-running.
module tb_uart_baud_gen;

    logic clk;
    logic rst_s;
    logic rst_d;
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    typedef struct {
        int   cyc;
        logic bnd;
        logic mid;
        int   ph;
    } ev_t;

    ev_t sbq[$];

    int d_last = -1;
    int d_os   = 0;
    int d_bit  = 0;

    localparam int DEF_END = 52005;

    uart_baud_gen_if #(.ACC_W(8), .OVERSAMPLE(16)) bs();
    uart_baud_gen_if bd();

    uart_baud_gen #(.ACC_W(8), .OVERSAMPLE(16), .DEFAULT_INC(64)) dut_s (
        .clkin (clk),
        .rst   (rst_s),
        .bus   (bs)
    );

    uart_baud_gen dut_d (
        .clkin (clk),
        .rst   (rst_d),
        .bus   (bd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: cycle %0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected ticks n_first..n_last of a run whose tick n lands at base + period*n
    // with oversample index (ph0 + n) mod 16.
    task automatic push_run(input int base, input int period, input int n_first,
                            input int n_last, input int ph0);
        ev_t e;
        for (int n = n_first; n <= n_last; n++) begin
            e.cyc = base + period * n;
            e.ph  = (ph0 + n) % 16;
            e.bnd = (e.ph == 0);
            e.mid = (e.ph == 8);
            sbq.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Scoreboard monitor for the small instance.
    always begin : mon_s
        ev_t me;
        @(posedge clk);
        #1;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            ntests++;
            nfail++;
            $display("FAIL tick_missing: no os_tick at cycle %0d (now %0d)", sbq[0].cyc, cyc);
            void'(sbq.pop_front());
        end
        if (bs.os_tick === 1'b1) begin
            if (sbq.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL tick_unexpected: os_tick at cycle %0d, none expected", cyc);
            end else begin
                me = sbq.pop_front();
                check("tick_cycle", cyc, me.cyc);
                check("tick_phase", int'(bs.os_phase), me.ph);
                check("bit_tick", int'(bs.bit_tick), int'(me.bnd));
                check("mid_tick", int'(bs.mid_tick), int'(me.mid));
            end
        end else if (bs.os_tick !== 1'b0 || bs.bit_tick !== 1'b0 || bs.mid_tick !== 1'b0) begin
            ntests++;
            nfail++;
            $display("FAIL stray_tick: cycle %0d os=%b bit=%b mid=%b expected all 0",
                     cyc, bs.os_tick, bs.bit_tick, bs.mid_tick);
        end
    end

    // Free-running monitor for the default instance: gap jitter and tick counts.
    always begin : mon_d
        int gap;
        @(posedge clk);
        #1;
        if (cyc <= DEF_END && bd.os_tick === 1'b1) begin
            if (d_last < 0) begin
                check("def_first_tick", cyc, 331);
            end else begin
                gap = cyc - d_last;
                ntests++;
                if (gap != 325 && gap != 326) begin
                    nfail++;
                    $display("FAIL def_gap: cycle %0d gap %0d expected 325 or 326", cyc, gap);
                end
            end
            d_last = cyc;
            d_os++;
            if (bd.bit_tick === 1'b1) d_bit++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_s = 1'b1;
        rst_d = 1'b1;
        bs.en = 1'b0; bs.resync = 1'b0; bs.inc_wr = 1'b0; bs.inc_in = '0;
        bd.en = 1'b1; bd.resync = 1'b0; bd.inc_wr = 1'b0; bd.inc_in = '0;

        push_run(5,   4, 1,  40, 0);  // steady run from reset release
        push_run(167, 4, 1,  32, 0);  // after resync; rate write pending until tick 32 wraps
        push_run(295, 2, 1,  20, 0);  // next bit at inc 128
        push_run(344, 4, 1,  5,  4);  // after en pause, rate 64 written while paused
        push_run(368, 4, 1,  16, 0);  // after mid-run reset
        push_run(432, 2, 1,  4,  0);  // rate written on the wrap cycle itself

        // Reset state.
        wait_cyc(3);
        check("rst_os_tick", int'(bs.os_tick), 0);
        check("rst_bit_tick", int'(bs.bit_tick), 0);
        check("rst_mid_tick", int'(bs.mid_tick), 0);
        check("rst_phase", int'(bs.os_phase), 0);
        check("rst_busy", int'(bs.inc_busy), 0);
        check("rst_def_phase", int'(bd.os_phase), 0);

        wait_cyc(5);
        rst_s = 1'b0;
        rst_d = 1'b0;
        bs.en = 1'b1;

        // Resync mid-bit.
        wait_cyc(166);
        bs.resync = 1'b1;
        wait_cyc(167);
        check("resync_phase", int'(bs.os_phase), 0);
        bs.resync = 1'b0;

        // Two writes while running: last one wins, held until the bit wrap.
        wait_cyc(251);
        bs.inc_wr = 1'b1;
        bs.inc_in = 8'd32;
        wait_cyc(252);
        check("pend_busy_set", int'(bs.inc_busy), 1);
        bs.inc_in = 8'd128;
        wait_cyc(253);
        bs.inc_wr = 1'b0;
        wait_cyc(294);
        check("pend_busy_hold", int'(bs.inc_busy), 1);
        wait_cyc(295);
        check("pend_busy_clear", int'(bs.inc_busy), 0);

        // Pause: phase frozen, write while paused applies at once.
        wait_cyc(336);
        bs.en = 1'b0;
        wait_cyc(340);
        check("pause_phase_a", int'(bs.os_phase), 4);
        bs.inc_wr = 1'b1;
        bs.inc_in = 8'd64;
        wait_cyc(341);
        bs.inc_wr = 1'b0;
        check("pause_wr_busy", int'(bs.inc_busy), 0);
        wait_cyc(346);
        check("pause_phase_b", int'(bs.os_phase), 4);
        bs.en = 1'b1;

        // Reset with a write pending at phase 9.
        wait_cyc(364);
        bs.inc_wr = 1'b1;
        bs.inc_in = 8'd200;
        wait_cyc(365);
        bs.inc_wr = 1'b0;
        check("prerst_busy", int'(bs.inc_busy), 1);
        check("prerst_phase", int'(bs.os_phase), 9);
        rst_s = 1'b1;
        wait_cyc(366);
        check("midrst_phase", int'(bs.os_phase), 0);
        check("midrst_busy", int'(bs.inc_busy), 0);
        check("midrst_tick", int'(bs.os_tick), 0);
        wait_cyc(368);
        rst_s = 1'b0;

        // Write landing on the wrap cycle goes straight in.
        wait_cyc(431);
        bs.inc_wr = 1'b1;
        bs.inc_in = 8'd128;
        wait_cyc(432);
        bs.inc_wr = 1'b0;
        check("wrap_wr_busy", int'(bs.inc_busy), 0);

        // Zero increment: no further ticks.
        wait_cyc(440);
        bs.en = 1'b0;
        bs.inc_wr = 1'b1;
        bs.inc_in = 8'd0;
        wait_cyc(441);
        bs.inc_wr = 1'b0;
        bs.en = 1'b1;
        check("zero_wr_busy", int'(bs.inc_busy), 0);
        wait_cyc(470);
        check("zero_phase_hold", int'(bs.os_phase), 4);
        wait_cyc(480);
        check("sb_drained", sbq.size(), 0);

        // Default-parameter instance totals.
        wait_cyc(DEF_END + 1);
        check("def_os_count", d_os, 159);
        ntests++;
        if (d_bit < 8 || d_bit > 10) begin
            nfail++;
            $display("FAIL def_bit_count: got %0d expected 9 (+/-1)", d_bit);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
